// File: rtl/check_req_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : check_req_arbiter_pkg
// Brief  : Shared widths, id field positions and seek-flag encodings for the
//          MAC-lookup request arbiter.
// Rev    : 1.0  initial release
// ============================================================================
package check_req_arbiter_pkg;

  localparam int MAC_W      = 48;
  localparam int ID_W       = 4;
  localparam int TAG_W      = 2;
  localparam int IDX_W      = 2;
  localparam int ID_REQ_MSB = 3;
  localparam int ID_REQ_LSB = 2;
  localparam int OUTPORT_W  = 3;
  localparam int OUTST_W    = 4;

  // Where the lookup engine found the destination.
  typedef enum logic [1:0] {
    SEEK_DDR  = 2'd0,
    SEEK_XBAR = 2'd1,
    SEEK_2HOP = 2'd2,
    SEEK_VLB  = 2'd3
  } seek_flag_e;

  // Lookup id = {requester index, requester-local tag}.
  function automatic logic [ID_W-1:0] make_id(input logic [IDX_W-1:0] idx,
                                              input logic [TAG_W-1:0] tag);
    return {idx, tag};
  endfunction

endpackage
`default_nettype wire

// File: rtl/check_req_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : check_req_arbiter_if
// Brief  : Bundle of requester, lookup and response signals around the
//          arbiter. Names carry the arbiter's point of view (i_ = into the
//          arbiter, o_ = out of it).
//   slave  : the arbiter itself
//   master : the environment (requesters, lookup engine, link status)
// Rev    : 1.0  initial release
// ============================================================================
interface check_req_arbiter_if #(
  parameter int P_REQ_NUM = 4
);
  import check_req_arbiter_pkg::*;

  // link status
  logic                         i_stat_rx_status;
  // requester side
  logic [P_REQ_NUM-1:0]         i_req_valid;
  logic [MAC_W*P_REQ_NUM-1:0]   i_req_mac;
  logic [TAG_W*P_REQ_NUM-1:0]   i_req_tag;
  logic [P_REQ_NUM-1:0]         o_req_ready;
  // lookup port
  logic [MAC_W-1:0]             o_check_mac;
  logic [ID_W-1:0]              o_check_id;
  logic                         o_check_valid;
  logic [OUTPORT_W-1:0]         i_outport;
  logic                         i_result_valid;
  logic [ID_W-1:0]              i_check_id;
  logic [1:0]                   i_seek_flag;
  // response to owners
  logic [P_REQ_NUM-1:0]         o_rsp_valid;
  logic [OUTPORT_W-1:0]         o_rsp_outport;
  logic [1:0]                   o_rsp_seek_flag;
  logic [TAG_W-1:0]             o_rsp_tag;
  // status
  logic [OUTST_W-1:0]           o_outstanding;
  logic                         o_err_timeout;

  modport slave (
    input  i_stat_rx_status, i_req_valid, i_req_mac, i_req_tag,
           i_outport, i_result_valid, i_check_id, i_seek_flag,
    output o_req_ready, o_check_mac, o_check_id, o_check_valid,
           o_rsp_valid, o_rsp_outport, o_rsp_seek_flag, o_rsp_tag,
           o_outstanding, o_err_timeout
  );

  modport master (
    output i_stat_rx_status, i_req_valid, i_req_mac, i_req_tag,
           i_outport, i_result_valid, i_check_id, i_seek_flag,
    input  o_req_ready, o_check_mac, o_check_id, o_check_valid,
           o_rsp_valid, o_rsp_outport, o_rsp_seek_flag, o_rsp_tag,
           o_outstanding, o_err_timeout
  );

endinterface
`default_nettype wire

// File: rtl/check_req_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : check_req_arbiter_rr_arbiter
// Brief  : N-way round-robin arbiter. Grants the first request at or after
//          the pointer; the pointer then moves one past the winner.
// Ports  : i_clk, i_rst_n  clock, async active-low reset
//          en_i            grant enable
//          req_i[N]        request vector
//          gnt_o[N]        one-hot grant (combinational)
//          gnt_idx_o       binary index of the grant
//          gnt_any_o       a grant is given this cycle
// Rev    : 1.0  initial release
// ============================================================================
module check_req_arbiter_rr_arbiter
  import check_req_arbiter_pkg::*;
#(
  parameter int P_REQ_NUM = 4
) (
  input  wire logic                 i_clk,
  input  wire logic                 i_rst_n,
  input  wire logic                 en_i,
  input  wire logic [P_REQ_NUM-1:0] req_i,
  output logic      [P_REQ_NUM-1:0] gnt_o,
  output logic      [IDX_W-1:0]     gnt_idx_o,
  output logic                      gnt_any_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;

  always_comb begin
    logic [IDX_W-1:0] k;
    k         = '0;
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_any_o = 1'b0;
    for (int i = 0; i < P_REQ_NUM; i++) begin
      k = IDX_W'((32'(ptr_q) + 32'(i)) % 32'(P_REQ_NUM));
      if (en_i && !gnt_any_o && req_i[k]) begin
        gnt_any_o = 1'b1;
        gnt_o[k]  = 1'b1;
        gnt_idx_o = k;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any_o) begin
      ptr_d = IDX_W'((32'(gnt_idx_o) + 32'd1) % 32'(P_REQ_NUM));
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/check_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module : check_req_arbiter
// Brief  : Shares one MAC-lookup port among P_REQ_NUM requesters. Round-robin
//          grant, one registered issue per grant, results routed back to the
//          owner by the id tag, bounded in-flight count, lost-result watchdog.
// Ports  : i_clk, i_rst_n   clock, async active-low reset
//          bus (slave)      requester / lookup / response / status bundle
// Params : P_REQ_NUM   requesters, 2..4
//          P_MAX_OUTST max lookups in flight, 1..15
//          P_TIMEOUT   idle cycles with lookups in flight before error
// Rev    : 1.0  initial release
// ============================================================================
module check_req_arbiter
  import check_req_arbiter_pkg::*;
#(
  parameter int P_REQ_NUM   = 4,
  parameter int P_MAX_OUTST = 4,
  parameter int P_TIMEOUT   = 64
) (
  input wire logic           i_clk,
  input wire logic           i_rst_n,
  check_req_arbiter_if.slave bus
);

  localparam int WD_W = $clog2(P_TIMEOUT + 1);

  // arbitration
  logic                 w_can_issue;
  logic [P_REQ_NUM-1:0] w_gnt;
  logic [IDX_W-1:0]     w_gnt_idx;
  logic                 w_gnt_any;

  // issue registers
  logic                 check_valid_q, check_valid_d;
  logic [MAC_W-1:0]     check_mac_q, check_mac_d;
  logic [ID_W-1:0]      check_id_q, check_id_d;

  // response registers
  logic [IDX_W-1:0]     w_rsp_idx;
  logic                 w_rsp_hit;
  logic [P_REQ_NUM-1:0] rsp_valid_q, rsp_valid_d;
  logic [OUTPORT_W-1:0] rsp_outport_q, rsp_outport_d;
  seek_flag_e           rsp_seek_q, rsp_seek_d;
  logic [TAG_W-1:0]     rsp_tag_q, rsp_tag_d;

  // in-flight tracking and watchdog
  logic                 w_inc, w_dec;
  logic [OUTST_W-1:0]   outst_q, outst_d;
  logic [WD_W-1:0]      wd_q, wd_d;
  logic                 err_q, err_d;

  // The lookup registered in the issue stage is counted here already so the
  // grant in the same cycle cannot push the in-flight total past the limit.
  assign w_can_issue = bus.i_stat_rx_status && !err_q &&
                       (({1'b0, outst_q} + {{OUTST_W{1'b0}}, check_valid_q})
                        < (OUTST_W+1)'(P_MAX_OUTST));

  check_req_arbiter_rr_arbiter #(
    .P_REQ_NUM (P_REQ_NUM)
  ) u_rr (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .en_i      (w_can_issue),
    .req_i     (bus.i_req_valid),
    .gnt_o     (w_gnt),
    .gnt_idx_o (w_gnt_idx),
    .gnt_any_o (w_gnt_any)
  );

  // Issue stage: capture the winner's MAC and tag, strobe one cycle later.
  always_comb begin
    check_valid_d = w_gnt_any;
    check_mac_d   = check_mac_q;
    check_id_d    = check_id_q;
    if (w_gnt_any) begin
      check_mac_d = bus.i_req_mac[w_gnt_idx*MAC_W +: MAC_W];
      check_id_d  = make_id(w_gnt_idx, bus.i_req_tag[w_gnt_idx*TAG_W +: TAG_W]);
    end
  end

  // Response demux; an id naming a non-existent requester is dropped.
  assign w_rsp_idx = bus.i_check_id[ID_REQ_MSB:ID_REQ_LSB];
  assign w_rsp_hit = bus.i_result_valid &&
                     ({{(32-IDX_W){1'b0}}, w_rsp_idx} < 32'(P_REQ_NUM));

  always_comb begin
    rsp_valid_d   = '0;
    rsp_outport_d = rsp_outport_q;
    rsp_seek_d    = rsp_seek_q;
    rsp_tag_d     = rsp_tag_q;
    if (w_rsp_hit) begin
      rsp_valid_d[w_rsp_idx] = 1'b1;
      rsp_outport_d          = bus.i_outport;
      rsp_seek_d             = seek_flag_e'(bus.i_seek_flag);
      rsp_tag_d              = bus.i_check_id[TAG_W-1:0];
    end
  end

  // In-flight counter. Results arriving with nothing in flight (e.g. stale
  // ones after a reset) do not decrement. Once the error is latched, late
  // issues are not counted so the count stays at zero.
  assign w_inc = check_valid_q && !err_q;
  assign w_dec = bus.i_result_valid && (outst_q != '0);

  always_comb begin
    outst_d = outst_q + OUTST_W'(w_inc) - OUTST_W'(w_dec);
    wd_d    = wd_q;
    err_d   = err_q;
    if (bus.i_result_valid || (outst_q == '0)) begin
      wd_d = '0;
    end else if (wd_q == WD_W'(P_TIMEOUT - 1)) begin
      wd_d    = '0;
      err_d   = 1'b1;
      outst_d = '0;
    end else begin
      wd_d = wd_q + WD_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      check_valid_q <= 1'b0;
      check_mac_q   <= '0;
      check_id_q    <= '0;
      rsp_valid_q   <= '0;
      rsp_outport_q <= '0;
      rsp_seek_q    <= SEEK_DDR;
      rsp_tag_q     <= '0;
      outst_q       <= '0;
      wd_q          <= '0;
      err_q         <= 1'b0;
    end else begin
      check_valid_q <= check_valid_d;
      check_mac_q   <= check_mac_d;
      check_id_q    <= check_id_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_outport_q <= rsp_outport_d;
      rsp_seek_q    <= rsp_seek_d;
      rsp_tag_q     <= rsp_tag_d;
      outst_q       <= outst_d;
      wd_q          <= wd_d;
      err_q         <= err_d;
    end
  end

  assign bus.o_req_ready     = w_gnt;
  assign bus.o_check_valid   = check_valid_q;
  assign bus.o_check_mac     = check_mac_q;
  assign bus.o_check_id      = check_id_q;
  assign bus.o_rsp_valid     = rsp_valid_q;
  assign bus.o_rsp_outport   = rsp_outport_q;
  assign bus.o_rsp_seek_flag = rsp_seek_q;
  assign bus.o_rsp_tag       = rsp_tag_q;
  assign bus.o_outstanding   = outst_q;
  assign bus.o_err_timeout   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_check_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_check_req_arbiter
// Brief  : Directed scoreboard bench for check_req_arbiter. Stimulus pushes
//          the expected lookup issues and owner responses into queues; a
//          monitor pops and compares whenever the DUT strobes one.
// Rev    : 1.0  initial release
// ============================================================================
module tb_check_req_arbiter;

  logic clk;
  logic rst_n;

  check_req_arbiter_if #(.P_REQ_NUM(4)) bus ();

  check_req_arbiter #(
    .P_REQ_NUM   (4),
    .P_MAX_OUTST (4),
    .P_TIMEOUT   (64)
  ) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [47:0] mac;
    logic [3:0]  id;
  } iss_t;

  typedef struct packed {
    logic [3:0] valid;
    logic [2:0] outport;
    logic [1:0] flag;
    logic [1:0] tag;
  } rsp_t;

  iss_t exp_iss[$];
  rsp_t exp_rsp[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [47:0] macv(input int k);
    return 48'hC0FFEE000000 | 48'(k);
  endfunction

  function automatic logic [1:0] tagv(input int k);
    return 2'(3 - k);
  endfunction

  task automatic set_req(input int k);
    bus.i_req_valid[k]          = 1'b1;
    bus.i_req_mac[48*k +: 48]   = macv(k);
    bus.i_req_tag[2*k +: 2]     = tagv(k);
  endtask

  task automatic push_iss(input int k);
    iss_t e;
    e.mac = macv(k);
    e.id  = {2'(k), tagv(k)};
    exp_iss.push_back(e);
  endtask

  // Drive one result strobe this cycle and record the owner response.
  task automatic drive_result(input logic [3:0] id, input logic [2:0] op, input logic [1:0] fl);
    rsp_t e;
    bus.i_result_valid = 1'b1;
    bus.i_check_id     = id;
    bus.i_outport      = op;
    bus.i_seek_flag    = fl;
    e.valid   = 4'b0001 << id[3:2];
    e.outport = op;
    e.flag    = fl;
    e.tag     = id[1:0];
    exp_rsp.push_back(e);
  endtask

  task automatic chk_ready(input string name, input logic [3:0] e);
    #1;
    check(name, 64'(bus.o_req_ready), 64'(e));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compare every issue and every owner response against the queues.
  always @(negedge clk) begin
    if (bus.o_check_valid) begin
      if (exp_iss.size() == 0) begin
        check("issue_unexpected", 64'(bus.o_check_id), 64'hFFFF);
      end else begin
        iss_t e;
        e = exp_iss.pop_front();
        check("issue_mac", 64'(bus.o_check_mac), 64'(e.mac));
        check("issue_id", 64'(bus.o_check_id), 64'(e.id));
      end
    end
    if (bus.o_rsp_valid != 4'b0000) begin
      if (exp_rsp.size() == 0) begin
        check("rsp_unexpected", 64'(bus.o_rsp_valid), 64'h0);
      end else begin
        rsp_t r;
        r = exp_rsp.pop_front();
        check("rsp_valid", 64'(bus.o_rsp_valid), 64'(r.valid));
        check("rsp_outport", 64'(bus.o_rsp_outport), 64'(r.outport));
        check("rsp_flag", 64'(bus.o_rsp_seek_flag), 64'(r.flag));
        check("rsp_tag", 64'(bus.o_rsp_tag), 64'(r.tag));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    rst_n                = 1'b0;
    bus.i_stat_rx_status = 1'b1;
    bus.i_req_valid      = '0;
    bus.i_req_mac        = '0;
    bus.i_req_tag        = '0;
    bus.i_result_valid   = 1'b0;
    bus.i_check_id       = '0;
    bus.i_outport        = '0;
    bus.i_seek_flag      = '0;
    repeat (3) @(negedge clk);

    // ---------------- reset state
    check("rst_ready", 64'(bus.o_req_ready), 64'h0);
    check("rst_check_valid", 64'(bus.o_check_valid), 64'h0);
    check("rst_check_mac", 64'(bus.o_check_mac), 64'h0);
    check("rst_check_id", 64'(bus.o_check_id), 64'h0);
    check("rst_rsp_valid", 64'(bus.o_rsp_valid), 64'h0);
    check("rst_outstanding", 64'(bus.o_outstanding), 64'h0);
    check("rst_err", 64'(bus.o_err_timeout), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // ---------------- single request from requester 1
    bus.i_req_valid[1]  = 1'b1;
    bus.i_req_mac[48 +: 48] = 48'h8DBC5C4A0102;
    bus.i_req_tag[2 +: 2]   = 2'd2;
    chk_ready("t1_ready", 4'b0010);
    exp_iss.push_back(iss_t'{48'h8DBC5C4A0102, 4'b0110});
    @(negedge clk);
    bus.i_req_valid = '0;
    chk_ready("t1_ready_off", 4'b0000);
    check("t1_outst_issue", 64'(bus.o_outstanding), 64'd0);
    @(negedge clk);
    check("t1_outst_1", 64'(bus.o_outstanding), 64'd1);
    drive_result(4'b0110, 3'd2, 2'd1);
    @(negedge clk);
    bus.i_result_valid = 1'b0;
    check("t1_outst_0", 64'(bus.o_outstanding), 64'd0);
    @(negedge clk);
    check("t1_mac_hold", 64'(bus.o_check_mac), 64'h8DBC5C4A0102);
    check("t1_rsp_hold", 64'(bus.o_rsp_outport), 64'd2);

    // ---------------- all four requesting continuously, pointer at 0
    do_reset();
    for (int k = 0; k < 4; k++) set_req(k);
    for (int c = 0; c < 4; c++) begin
      chk_ready("t2_rr_grant", 4'(1 << c));
      push_iss(c);
      @(negedge clk);
    end
    chk_ready("t2_blocked_a", 4'b0000);
    @(negedge clk);
    chk_ready("t2_blocked_b", 4'b0000);
    check("t2_outst_max", 64'(bus.o_outstanding), 64'd4);
    @(negedge clk);
    drive_result({2'd0, tagv(0)}, 3'd5, 2'd0);
    chk_ready("t2_blocked_c", 4'b0000);
    @(negedge clk);
    bus.i_result_valid = 1'b0;
    chk_ready("t2_resume", 4'b0001);
    push_iss(0);
    check("t2_outst_3", 64'(bus.o_outstanding), 64'd3);
    @(negedge clk);
    bus.i_req_valid = '0;
    @(negedge clk);
    check("t2_outst_4b", 64'(bus.o_outstanding), 64'd4);
    drive_result({2'd1, tagv(1)}, 3'd1, 2'd2);

    // ---------------- result and issue in the same cycle at 3 in flight
    @(negedge clk);
    bus.i_result_valid = 1'b0;
    check("t3_outst_3", 64'(bus.o_outstanding), 64'd3);
    set_req(2);
    chk_ready("t3_ready2", 4'b0100);
    push_iss(2);
    @(negedge clk);
    bus.i_req_valid = '0;
    drive_result({2'd2, tagv(2)}, 3'd3, 2'd3);
    check("t3_outst_pre", 64'(bus.o_outstanding), 64'd3);
    @(negedge clk);
    check("t3_inc_dec_same", 64'(bus.o_outstanding), 64'd3);
    drive_result({2'd3, tagv(3)}, 3'd6, 2'd1);
    @(negedge clk);
    drive_result({2'd0, tagv(0)}, 3'd7, 2'd2);
    @(negedge clk);
    drive_result({2'd2, tagv(2)}, 3'd0, 2'd3);
    @(negedge clk);
    bus.i_result_valid = 1'b0;
    check("t3_drained", 64'(bus.o_outstanding), 64'd0);
    drive_result({2'd1, tagv(1)}, 3'd4, 2'd0);
    @(negedge clk);
    bus.i_result_valid = 1'b0;
    check("t3_no_underflow", 64'(bus.o_outstanding), 64'd0);

    // ---------------- link drop one cycle after a grant (pointer now at 3)
    set_req(3);
    chk_ready("t4_ready3", 4'b1000);
    push_iss(3);
    @(negedge clk);
    bus.i_stat_rx_status = 1'b0;
    bus.i_req_valid      = '0;
    set_req(0);
    chk_ready("t4_link_down_a", 4'b0000);
    @(negedge clk);
    chk_ready("t4_link_down_b", 4'b0000);
    check("t4_inflight", 64'(bus.o_outstanding), 64'd1);
    @(negedge clk);
    bus.i_stat_rx_status = 1'b1;
    chk_ready("t4_link_up", 4'b0001);
    push_iss(0);
    @(negedge clk);
    bus.i_req_valid = '0;
    @(negedge clk);
    check("t4_outst_2", 64'(bus.o_outstanding), 64'd2);
    drive_result({2'd3, tagv(3)}, 3'd2, 2'd1);
    @(negedge clk);
    drive_result({2'd0, tagv(0)}, 3'd3, 2'd2);
    @(negedge clk);
    bus.i_result_valid = 1'b0;
    check("t4_drained", 64'(bus.o_outstanding), 64'd0);

    // ---------------- watchdog timeout with 2 in flight
    do_reset();
    set_req(0);
    set_req(1);
    chk_ready("t5_ready0", 4'b0001);
    push_iss(0);
    @(negedge clk);
    bus.i_req_valid[0] = 1'b0;
    chk_ready("t5_ready1", 4'b0010);
    push_iss(1);
    @(negedge clk);
    bus.i_req_valid = '0;
    // first cycle with a lookup in flight; the error appears 64 cycles later
    check("t5_outst_1", 64'(bus.o_outstanding), 64'd1);
    repeat (63) @(negedge clk);
    check("t5_err_not_yet", 64'(bus.o_err_timeout), 64'd0);
    check("t5_outst_2", 64'(bus.o_outstanding), 64'd2);
    @(negedge clk);
    check("t5_err_set", 64'(bus.o_err_timeout), 64'd1);
    check("t5_outst_forced", 64'(bus.o_outstanding), 64'd0);
    set_req(2);
    for (int c = 0; c < 3; c++) begin
      chk_ready("t5_no_grant", 4'b0000);
      @(negedge clk);
    end
    check("t5_err_sticky", 64'(bus.o_err_timeout), 64'd1);
    bus.i_req_valid = '0;
    do_reset();
    check("t5_err_cleared", 64'(bus.o_err_timeout), 64'd0);

    // ---------------- reset with 3 in flight, then a stale result
    for (int k = 0; k < 3; k++) set_req(k);
    for (int c = 0; c < 3; c++) begin
      chk_ready("t6_grant", 4'(1 << c));
      push_iss(c);
      @(negedge clk);
      bus.i_req_valid[c] = 1'b0;
    end
    @(negedge clk);
    check("t6_outst_3", 64'(bus.o_outstanding), 64'd3);
    rst_n = 1'b0;
    #1;
    check("t6_async_clear", 64'(bus.o_outstanding), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("t6_err_after_rst", 64'(bus.o_err_timeout), 64'd0);
    drive_result({2'd1, tagv(1)}, 3'd4, 2'd2);
    @(negedge clk);
    bus.i_result_valid = 1'b0;
    check("t6_stale_outst", 64'(bus.o_outstanding), 64'd0);
    @(negedge clk);
    check("t6_stale_outst_b", 64'(bus.o_outstanding), 64'd0);

    repeat (2) @(negedge clk);
    check("end_iss_queue_empty", 64'(exp_iss.size()), 64'd0);
    check("end_rsp_queue_empty", 64'(exp_rsp.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
